rx_packet_assembler: RTL and testbench
======================================

RX_PACKET_ASSEMBLER -- requirements
Module: rx_packet_assembler

Interface
REQ-001 SHALL have port clock, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port in_bit, input, 1: serial bit from the CRC16 decode stage, LSB-first, PID then payload; the 16 CRC bits are stripped upstream.
REQ-004 SHALL have port in_valid, input, 1: in_bit is valid this cycle (CRC stage sending).
REQ-005 SHALL have port eop, input, 1: one-cycle end-of-packet pulse, no earlier than one cycle after the last in_valid.
REQ-006 SHALL have port crc_valid, input, 1: CRC16 residue good, sampled only on eop.
REQ-007 SHALL have port pkt_ack, input, 1: consumer accepts the held packet.
REQ-008 SHALL have port pid, output, 4: received PID nibble (bits 3:0 of the PID byte).
REQ-009 SHALL have port data, output, 64: payload; received bit k lands in data[k]; unused bits are 0.
REQ-010 SHALL have port byte_count, output, 4: whole payload bytes received, 0..8.
REQ-011 SHALL have port pkt_type, output, 2: 00 invalid, 01 token, 10 data, 11 handshake.
REQ-012 SHALL have outputs pid_err, crc_err, len_err, overrun, each 1 bit: error flags, valid while pkt_ready=1.
REQ-013 SHALL have outputs pkt_ready and busy, each 1 bit: result held / packet in progress.

Function
REQ-014 SHALL implement states IDLE, PID, PAYLOAD, DONE.
- IDLE->PID on in_valid, with that bit captured as PID bit 0.
- PID->PAYLOAD after the 8th PID bit.
- PID or PAYLOAD->DONE on eop.
- DONE->IDLE on pkt_ack.
REQ-015 SHALL set busy=1 in PID and PAYLOAD only.
REQ-016 SHALL use a 7-bit payload bit counter; bits arriving after 64 payload bits are dropped and set len_err.
REQ-017 SHALL classify the PID:
- 0001, 1001, 1101 -> token.
- 0011, 1011 -> data.
- 0010, 1010, 1110 -> handshake.
- any other PID -> invalid (pkt_type=00, pid_err=1).
REQ-018 SHALL set len_err at completion in any of these cases:
- token payload is not exactly 16 bits;
- handshake payload is not 0 bits;
- data payload is not a multiple of 8 bits or exceeds 64 bits;
- eop arrives in state PID (fewer than 8 PID bits).
REQ-019 SHALL set crc_err = ~crc_valid, sampled on eop, for data packets only; crc_err=0 for all other types.
REQ-020 SHALL assert pkt_ready the cycle after eop; all outputs SHALL hold until pkt_ack, and pkt_ready SHALL drop the cycle after pkt_ack.
REQ-021 SHALL ignore in_valid while in DONE and SHALL latch overrun=1; overrun SHALL clear on pkt_ack.
REQ-022 SHALL give priority to pkt_ack when pkt_ack and in_valid occur in the same DONE cycle: go to IDLE and drop that bit (overrun=1 is reported on the next packet).
REQ-023 SHALL ignore eop in IDLE and in DONE.
REQ-024 SHALL clear data, byte_count and all flags on the IDLE->PID transition.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously force state IDLE and all outputs to 0, including pid, data, pkt_type, pkt_ready and busy.
REQ-026 SHALL, on reset asserted mid-packet, discard the partial packet; after release the block SHALL wait in IDLE for a fresh in_valid.

Configuration
REQ-027 SHALL check the PID complement only when macro RX_PID_CHECK_EN is defined.
- Defined: PID bits 7:4 != ~bits 3:0 sets pid_err=1 and pkt_type=00.
- Undefined: bits 7:4 are ignored; pid_err is set only for an unknown nibble (REQ-017).

Verification
REQ-028 SHALL pass: PID byte 0xC3 then 64 payload bits of 0x0123456789ABCDEF, eop, crc_valid=1 -> pkt_type=10, pid=3, data=0x0123456789ABCDEF, byte_count=8, all error flags 0.
REQ-029 SHALL pass: PID byte 0xD2, no payload, eop, crc_valid=0 -> pkt_type=11, pid=2, crc_err=0, len_err=0, byte_count=0.
REQ-030 SHALL pass: PID byte 0x4B, 20 payload bits, eop, crc_valid=0 -> pkt_type=10, len_err=1, crc_err=1, byte_count=2.
REQ-031 SHALL pass, with RX_PID_CHECK_EN defined: PID byte 0xF3 -> pid_err=1, pkt_type=00; with it undefined -> pid_err=0, pkt_type=10.
REQ-032 SHALL pass: packet held with no pkt_ack, second packet starts -> overrun=1 and first packet's data unchanged; pkt_ack -> pkt_ready=0 and overrun=0 next cycle.
REQ-033 SHALL pass: reset_n pulsed low after 30 payload bits -> all outputs 0 immediately; a following 0xC3 packet with 8 payload bits gives byte_count=1.

Source files
------------

// File: rtl/rx_packet_assembler.sv
// rx_packet_assembler
// Builds one received packet from the serial bit stream that leaves the CRC16
// decode stage. The PID byte and then the payload arrive LSB-first; the CRC bits
// have already been removed. On eop the packet is classified and checked, and
// the result is held until the consumer pulses pkt_ack.
//
// Ports
//   clock, reset_n       rising-edge clock; asynchronous active-low reset
//   in_bit, in_valid     serial bit and its qualifier
//   eop, crc_valid       end-of-packet pulse; CRC residue status, sampled on eop
//   pkt_ack              consumer accepts the held packet
//   pid, pkt_type        PID nibble and its class (00 inv, 01 token, 10 data, 11 hs)
//   data, byte_count     payload (bit k in data[k]) and number of whole bytes
//   pid_err, crc_err,
//   len_err, overrun     error flags, meaningful while pkt_ready=1
//   pkt_ready, busy      result held / packet in progress
//
// Build option
//   RX_PID_CHECK_EN      when defined, PID bits 7:4 must be the complement of 3:0
//
// state   | meaning
// IDLE    | waiting for the first PID bit
// PID     | shifting in the 8 PID bits
// PAYLOAD | storing payload bits, up to 64
// DONE    | result held until pkt_ack
module rx_packet_assembler (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        eop,
  input  logic        crc_valid,
  input  logic        pkt_ack,
  output logic [3:0]  pid,
  output logic [63:0] data,
  output logic [3:0]  byte_count,
  output logic [1:0]  pkt_type,
  output logic        pid_err,
  output logic        crc_err,
  output logic        len_err,
  output logic        overrun,
  output logic        pkt_ready,
  output logic        busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PID     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] T_INV   = 2'b00;
  localparam logic [1:0] T_TOKEN = 2'b01;
  localparam logic [1:0] T_DATA  = 2'b10;
  localparam logic [1:0] T_HS    = 2'b11;

  logic [1:0]  r_state;
  logic [7:0]  r_pid_sr;
  logic [2:0]  r_pid_cnt;
  logic [63:0] r_data;
  logic [6:0]  r_bit_cnt;
  logic        r_drop;
  logic        r_ovr_pend;
  logic [3:0]  r_pid;
  logic [3:0]  r_byte_count;
  logic [1:0]  r_pkt_type;
  logic        r_pid_err;
  logic        r_crc_err;
  logic        r_len_err;
  logic        r_overrun;

  logic        w_finish;
  logic [1:0]  w_type;
  logic        w_len_bad;

  assign w_finish = eop && ((r_state == S_PID) || (r_state == S_PAYLOAD));

  // The PID shifts in from the top, so after 8 bits the byte sits LSB-aligned.
  always_comb begin
    w_type = T_INV;
    case (r_pid_sr[3:0])
      4'h1, 4'h9, 4'hD: w_type = T_TOKEN;
      4'h3, 4'hB:       w_type = T_DATA;
      4'h2, 4'hA, 4'hE: w_type = T_HS;
      default:          w_type = T_INV;
    endcase
`ifdef RX_PID_CHECK_EN
    if (r_pid_sr[7:4] != ~r_pid_sr[3:0]) w_type = T_INV;
`endif
  end

  // Over-length data packets are caught by r_drop, the counter saturates at 64.
  always_comb begin
    w_len_bad = r_drop || (r_state == S_PID);
    case (w_type)
      T_TOKEN: if (r_bit_cnt != 7'd16) w_len_bad = 1'b1;
      T_HS:    if (r_bit_cnt != 7'd0) w_len_bad = 1'b1;
      T_DATA:  if (r_bit_cnt[2:0] != 3'd0) w_len_bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pid_sr     <= '0;
      r_pid_cnt    <= '0;
      r_data       <= '0;
      r_bit_cnt    <= '0;
      r_drop       <= 1'b0;
      r_ovr_pend   <= 1'b0;
      r_pid        <= '0;
      r_byte_count <= '0;
      r_pkt_type   <= '0;
      r_pid_err    <= 1'b0;
      r_crc_err    <= 1'b0;
      r_len_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_finish) begin
      r_state      <= S_DONE;
      r_pid        <= r_pid_sr[3:0];
      r_pkt_type   <= w_type;
      r_pid_err    <= (w_type == T_INV);
      r_crc_err    <= (w_type == T_DATA) && !crc_valid;
      r_len_err    <= w_len_bad;
      r_byte_count <= r_bit_cnt[6:3];
      // A bit lost in an ack/in_valid collision is reported on this packet.
      r_overrun    <= r_ovr_pend;
      r_ovr_pend   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state      <= S_PID;
            r_pid_sr     <= {in_bit, 7'd0};
            r_pid_cnt    <= 3'd1;
            r_data       <= '0;
            r_bit_cnt    <= '0;
            r_drop       <= 1'b0;
            r_byte_count <= '0;
            r_pid_err    <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_overrun    <= 1'b0;
          end
        end
        S_PID: begin
          if (in_valid) begin
            r_pid_sr  <= {in_bit, r_pid_sr[7:1]};
            r_pid_cnt <= r_pid_cnt + 3'd1;
            if (r_pid_cnt == 3'd7) r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            if (r_bit_cnt[6]) begin
              r_drop <= 1'b1;
            end else begin
              r_data[r_bit_cnt[5:0]] <= in_bit;
              r_bit_cnt              <= r_bit_cnt + 7'd1;
            end
          end
        end
        default: begin
          if (pkt_ack) begin
            r_state    <= S_IDLE;
            r_overrun  <= 1'b0;
            r_ovr_pend <= in_valid;
          end else if (in_valid) begin
            r_overrun <= 1'b1;
          end
        end
      endcase
    end
  end

  assign pid        = r_pid;
  assign data       = r_data;
  assign byte_count = r_byte_count;
  assign pkt_type   = r_pkt_type;
  assign pid_err    = r_pid_err;
  assign crc_err    = r_crc_err;
  assign len_err    = r_len_err;
  assign overrun    = r_overrun;
  assign pkt_ready  = (r_state == S_DONE);
  assign busy       = (r_state == S_PID) || (r_state == S_PAYLOAD);

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Directed bench for rx_packet_assembler. Result fields are packed as
// {pkt_ready, busy, pkt_type, pid, byte_count, pid_err, crc_err, len_err, overrun}.
module tb_rx_packet_assembler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        eop = 1'b0;
  logic        crc_valid = 1'b0;
  logic        pkt_ack = 1'b0;
  logic [3:0]  pid;
  logic [63:0] data;
  logic [3:0]  byte_count;
  logic [1:0]  pkt_type;
  logic        pid_err, crc_err, len_err, overrun, pkt_ready, busy;
  logic [15:0] res;
  logic [15:0] exp_res;

  int checks = 0;
  int errors = 0;

  rx_packet_assembler dut (
    .clock(clock), .reset_n(reset_n), .in_bit(in_bit), .in_valid(in_valid),
    .eop(eop), .crc_valid(crc_valid), .pkt_ack(pkt_ack), .pid(pid), .data(data),
    .byte_count(byte_count), .pkt_type(pkt_type), .pid_err(pid_err),
    .crc_err(crc_err), .len_err(len_err), .overrun(overrun),
    .pkt_ready(pkt_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  assign res = {pkt_ready, busy, pkt_type, pid, byte_count, pid_err, crc_err, len_err, overrun};

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = v[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic pulse_eop(input logic crc);
    eop = 1'b1;
    crc_valid = crc;
    @(posedge clock); #1;
    eop = 1'b0;
    crc_valid = 1'b0;
  endtask

  task automatic do_ack();
    pkt_ack = 1'b1;
    @(posedge clock); #1;
    pkt_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (res !== 16'h0000) begin
      errors++; $display("FAIL reset_fields got %h want %h", res, 16'h0000);
    end
    checks++;
    if (data !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", data);
    end
  endtask

  task automatic test_data_full();
    send_bits({56'h0, 64'h0123456789ABCDEF, 8'hC3}, 72);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL full_busy got %b want 1", busy);
    end
    pulse_eop(1'b1);
    exp_res = {1'b1, 1'b0, 2'b10, 4'h3, 4'd8, 4'b0000};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL full_fields got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL full_data got %h want 0123456789abcdef", data);
    end
    do_ack();
    checks++;
    if ({pkt_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL full_ack got %b want 00", {pkt_ready, busy});
    end
  endtask

  task automatic test_handshake();
    send_bits({120'h0, 8'hD2}, 8);
    pulse_eop(1'b0);
    exp_res = {1'b1, 1'b0, 2'b11, 4'h2, 4'd0, 4'b0000};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL handshake got %h want %h", res, exp_res);
    end
    do_ack();
  endtask

  task automatic test_short_data();
    send_bits({100'h0, 20'hABCDE, 8'h4B}, 28);
    pulse_eop(1'b0);
    exp_res = {1'b1, 1'b0, 2'b10, 4'hB, 4'd2, 4'b0110};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL short_data got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'hABCDE) begin
      errors++; $display("FAIL short_data_bits got %h want abcde", data);
    end
    do_ack();
  endtask

  task automatic test_pid_check();
    send_bits({112'h0, 8'h5A, 8'hF3}, 16);
    pulse_eop(1'b1);
`ifdef RX_PID_CHECK_EN
    exp_res = {1'b1, 1'b0, 2'b00, 4'h3, 4'd1, 4'b1000};
`else
    exp_res = {1'b1, 1'b0, 2'b10, 4'h3, 4'd1, 4'b0000};
`endif
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL pid_check got %h want %h", res, exp_res);
    end
    do_ack();
  endtask

  task automatic test_token();
    send_bits({104'h0, 16'h1234, 8'hE1}, 24);
    pulse_eop(1'b0);
    exp_res = {1'b1, 1'b0, 2'b01, 4'h1, 4'd2, 4'b0000};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL token_ok got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'h1234) begin
      errors++; $display("FAIL token_data got %h want 1234", data);
    end
    do_ack();
    send_bits({112'h0, 8'h77, 8'hE1}, 16);
    pulse_eop(1'b1);
    exp_res = {1'b1, 1'b0, 2'b01, 4'h1, 4'd1, 4'b0010};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL token_len got %h want %h", res, exp_res);
    end
    do_ack();
  endtask

  task automatic test_invalid_pid();
    send_bits({120'h0, 8'hF0}, 8);
    pulse_eop(1'b0);
    exp_res = {1'b1, 1'b0, 2'b00, 4'h0, 4'd0, 4'b1000};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL invalid_pid got %h want %h", res, exp_res);
    end
    do_ack();
  endtask

  task automatic test_short_pid();
    send_bits({124'h0, 4'h3}, 4);
    pulse_eop(1'b1);
    checks++;
    if ({pkt_ready, busy, len_err} !== 3'b101) begin
      errors++; $display("FAIL short_pid got %b want 101", {pkt_ready, busy, len_err});
    end
    do_ack();
  endtask

  task automatic test_overflow();
    send_bits({48'h0, 8'hFF, 64'h0123456789ABCDEF, 8'hC3}, 80);
    pulse_eop(1'b1);
    exp_res = {1'b1, 1'b0, 2'b10, 4'h3, 4'd8, 4'b0010};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL overflow got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL overflow_data got %h want 0123456789abcdef", data);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    send_bits({112'h0, 8'hA5, 8'hC3}, 16);
    pulse_eop(1'b1);
    send_bits({123'h0, 5'b01101}, 5);
    exp_res = {1'b1, 1'b0, 2'b10, 4'h3, 4'd1, 4'b0001};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL overrun_set got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'hA5) begin
      errors++; $display("FAIL overrun_data got %h want a5", data);
    end
    do_ack();
    checks++;
    if ({pkt_ready, overrun} !== 2'b00) begin
      errors++; $display("FAIL overrun_clear got %b want 00", {pkt_ready, overrun});
    end
    pulse_eop(1'b1);
    checks++;
    if ({pkt_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_eop got %b want 00", {pkt_ready, busy});
    end
  endtask

  task automatic test_ack_collision();
    send_bits({120'h0, 8'hD2}, 8);
    pulse_eop(1'b1);
    pkt_ack  = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clock); #1;
    pkt_ack  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    checks++;
    if ({pkt_ready, busy, overrun} !== 3'b000) begin
      errors++; $display("FAIL collide_ack got %b want 000", {pkt_ready, busy, overrun});
    end
    send_bits({120'h0, 8'hD2}, 8);
    pulse_eop(1'b1);
    exp_res = {1'b1, 1'b0, 2'b11, 4'h2, 4'd0, 4'b0001};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL collide_next got %h want %h", res, exp_res);
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    send_bits({90'h0, 30'h2AAA_5555, 8'hC3}, 38);
    reset_n = 1'b0;
    #1;
    checks++;
    if (res !== 16'h0000) begin
      errors++; $display("FAIL midreset_fields got %h want 0000", res);
    end
    checks++;
    if (data !== 64'h0) begin
      errors++; $display("FAIL midreset_data got %h want 0", data);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    send_bits({112'h0, 8'h7E, 8'hC3}, 16);
    pulse_eop(1'b1);
    exp_res = {1'b1, 1'b0, 2'b10, 4'h3, 4'd1, 4'b0000};
    checks++;
    if (res !== exp_res) begin
      errors++; $display("FAIL after_reset got %h want %h", res, exp_res);
    end
    checks++;
    if (data !== 64'h7E) begin
      errors++; $display("FAIL after_reset_data got %h want 7e", data);
    end
    do_ack();
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_data_full();
    test_handshake();
    test_short_data();
    test_pid_check();
    test_token();
    test_invalid_pid();
    test_short_pid();
    test_overflow();
    test_overrun();
    test_ack_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
